// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, colour palette, drawer FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: coord_t (9-bit coordinate), colour_t, SCREEN_WIDTH/HEIGHT, colour names, S_* states.
package pong_pkg;

  // Coordinate type shared with the location processors.
  typedef logic [8:0] coord_t;
  typedef logic [2:0] colour_t;

  localparam coord_t SCREEN_WIDTH  = 9'd320;
  localparam coord_t SCREEN_HEIGHT = 9'd240;

  localparam colour_t BLACK   = 3'b000;
  localparam colour_t BLUE    = 3'b001;
  localparam colour_t GREEN   = 3'b010;
  localparam colour_t CYAN    = 3'b011;
  localparam colour_t RED     = 3'b100;
  localparam colour_t MAGENTA = 3'b101;
  localparam colour_t YELLOW  = 3'b110;
  localparam colour_t WHITE   = 3'b111;

  // Box drawer state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/box_drawer_rect_scanner.sv
// Row-major W x H offset counter; dx runs fastest, dy steps when dx wraps.
// Latency: offsets are registered; start/advance take effect on the next edge.
// Backpressure: none; the caller advances exactly one pixel per cycle while scanning.
// Ports: clock, reset_n, start (clear to 0,0; wins over advance), advance, dx, dy, last.
module rect_scanner import pong_pkg::*; #(
  parameter coord_t W = 9'd10,
  parameter coord_t H = 9'd48
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   start,
  input  logic   advance,
  output coord_t dx,
  output coord_t dy,
  output logic   last
);

  localparam coord_t W_LAST = W - 9'd1;
  localparam coord_t H_LAST = H - 9'd1;

  coord_t dx_q, dx_d;
  coord_t dy_q, dy_d;
  logic   row_end;

  assign row_end = (dx_q == W_LAST);
  assign last    = row_end && (dy_q == H_LAST);
  assign dx      = dx_q;
  assign dy      = dy_q;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start) begin
      dx_d = '0;
      dy_d = '0;
    end else if (advance) begin
      if (row_end) begin
        dx_d = '0;
        // Wrap the whole rectangle after the final pixel so a new scan starts clean.
        dy_d = last ? '0 : dy_q + 9'd1;
      end else begin
        dx_d = dx_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/box_drawer.sv
// Erases the box at its previous position, then draws it at the newly accepted one, one pixel per cycle.
// Latency: first vga_plot on the second edge after transfer; frame_done W*H+2 (no erase) or 2*W*H+2 edges counting the transfer edge.
// Backpressure: s_ready is high only in S_IDLE (pure state decode); the word is latched on transfer.
// Ports: clock, reset_n; s_valid/s_ready/s_x/s_y/s_color in; vga_x/vga_y/vga_colour/vga_plot, frame_done out.
module box_drawer import pong_pkg::*; #(
  parameter logic [8:0] BOX_WIDTH     = 9'd10,
  parameter logic [8:0] BOX_HEIGHT    = 9'd48,
  parameter logic [8:0] SCREEN_WIDTH  = pong_pkg::SCREEN_WIDTH,
  parameter logic [8:0] SCREEN_HEIGHT = pong_pkg::SCREEN_HEIGHT,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] s_x,
  input  logic [8:0] s_y,
  input  logic [2:0] s_color,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       frame_done
);

  logic [1:0] state_q, state_d;
  coord_t     cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  colour_t    cur_color_q, cur_color_d;
  coord_t     prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic       has_prev_q, has_prev_d;

  logic [8:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       frame_done_q, frame_done_d;

  logic       scan_start, scan_adv, scan_last, scanning;
  coord_t     dx, dy, base_x, base_y;
  colour_t    pix_colour;
  logic [9:0] px, py;

  rect_scanner #(.W(BOX_WIDTH), .H(BOX_HEIGHT)) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (scan_start),
    .advance (scan_adv),
    .dx      (dx),
    .dy      (dy),
    .last    (scan_last)
  );

  assign s_ready = (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_color_d  = cur_color_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    has_prev_d   = has_prev_q;
    scan_start   = 1'b0;
    scan_adv     = 1'b0;
    scanning     = 1'b0;
    base_x       = cur_x_q;
    base_y       = cur_y_q;
    pix_colour   = cur_color_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          cur_x_d     = s_x;
          cur_y_d     = s_y;
          cur_color_d = s_color;
          scan_start  = 1'b1;
          // Nothing to erase on the first word or when the box has not moved.
          if (has_prev_q && ((prev_x_q != s_x) || (prev_y_q != s_y))) begin
            state_d = S_ERASE;
          end else begin
            state_d = S_DRAW;
          end
        end
      end
      S_ERASE: begin
        scanning   = 1'b1;
        scan_adv   = 1'b1;
        base_x     = prev_x_q;
        base_y     = prev_y_q;
        pix_colour = BG_COLOR;
        if (scan_last) begin
          scan_start = 1'b1;
          state_d    = S_DRAW;
        end
      end
      S_DRAW: begin
        scanning = 1'b1;
        scan_adv = 1'b1;
        if (scan_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        prev_x_d     = cur_x_q;
        prev_y_d     = cur_y_q;
        has_prev_d   = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // 10-bit sums so a box hanging off the right/bottom edge clips instead of wrapping.
    px = {1'b0, base_x} + {1'b0, dx};
    py = {1'b0, base_y} + {1'b0, dy};

    vga_plot_d   = scanning && (px < {1'b0, SCREEN_WIDTH}) && (py < {1'b0, SCREEN_HEIGHT});
    vga_x_d      = scanning ? px[8:0] : vga_x_q;
    vga_y_d      = scanning ? py[7:0] : vga_y_q;
    vga_colour_d = scanning ? pix_colour : vga_colour_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_color_q  <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      has_prev_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_color_q  <= cur_color_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      has_prev_q   <= has_prev_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign frame_done = frame_done_q;

endmodule
